// File: rtl/crack_result_collector_pkg.sv
// Shared types and constants for the RC4 crack result collector.
// State encodings, default widths and the key-space bound shared with the cores.
package crack_result_collector_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LAUNCH = 3'd1,
      ST_RUN    = 3'd2,
      ST_FOUND  = 3'd3,
      ST_FAIL   = 3'd4
   } state_e;

   localparam int          KEY_W_DEF = 24;
   localparam int          CNT_W_DEF = 32;
   localparam logic [23:0] MAX_KEY   = 24'h3FFFFF;

endpackage

// File: rtl/crack_result_collector_lowest_bit_enc.sv
// Lowest-index-wins priority encoder: request vector in, {any, idx} out.
// Purely combinational; unused high bits of idx stay 0.
module lowest_bit_enc #(
   parameter int N = 4
) (
   input  logic [N-1:0] req_i,
   output logic         any_o,
   output logic [2:0]   idx_o
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      any_o = 1'b0;
      idx_o = 3'd0;
      for (int i = N - 1; i >= 0; i--) begin
         idx_o = req_i[i] ? 3'(i) : idx_o;
         any_o = any_o | req_i[i];
      end
   end

endmodule

// File: rtl/crack_result_collector.sv
// Supervisor for N parallel RC4 cracking cores: launches them, latches the first
// winning key and core index, then parks every core in reset and reports status.
module crack_result_collector
   import crack_result_collector_pkg::*;
#(
   parameter int NUM_CORES = 4,
   parameter int KEY_W     = KEY_W_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       start_i,
   input  logic [NUM_CORES-1:0]       core_found_i,
   input  logic [NUM_CORES-1:0]       core_exhausted_i,
   input  logic [NUM_CORES*KEY_W-1:0] core_key_i,
   output logic                       core_rst_o,
   output logic                       core_start_o,
   output logic [KEY_W-1:0]           key_out_o,
   output logic [2:0]                 winner_idx_o,
   output logic                       key_valid_o,
   output logic                       no_key_o,
   output logic                       busy_o,
   output logic [CNT_W-1:0]           cycles_o
);

   state_e           state_q, state_d;
   logic             launch_ph_q, launch_ph_d;
   logic             core_rst_q, core_rst_d;
   logic             core_start_q, core_start_d;
   logic [KEY_W-1:0] key_q, key_d;
   logic [2:0]       idx_q, idx_d;
   logic             key_valid_q, key_valid_d;
   logic             no_key_q, no_key_d;
   logic             busy_q, busy_d;
   logic [CNT_W-1:0] cycles_q;

   logic             any_found_s;
   logic [2:0]       win_idx_s;
   logic [KEY_W-1:0] sel_key_s;
   logic             all_exh_s;
   logic             launch_s;

   lowest_bit_enc #(
      .N (NUM_CORES)
   ) u_enc (
      .req_i (core_found_i),
      .any_o (any_found_s),
      .idx_o (win_idx_s)
   );

   assign all_exh_s = &core_exhausted_i;

   // Mux out the winning core's key slice.
   always_comb begin
      sel_key_s = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         sel_key_s = (win_idx_s == 3'(i)) ? core_key_i[i*KEY_W +: KEY_W] : sel_key_s;
      end
   end

   // Next-state and next-output logic; registered outputs mean each branch sets
   // the values seen during the cycle after the transition.
   always_comb begin
      state_d      = state_q;
      launch_ph_d  = 1'b0;
      core_rst_d   = 1'b1;
      core_start_d = 1'b0;
      key_d        = key_q;
      idx_d        = idx_q;
      key_valid_d  = 1'b0;
      no_key_d     = 1'b0;
      busy_d       = 1'b0;
      launch_s     = 1'b0;

      case (state_q)
         ST_IDLE, ST_FOUND, ST_FAIL: begin
            if (start_i) begin
               state_d  = ST_LAUNCH;
               launch_s = 1'b1;
               busy_d   = 1'b1;
               key_d    = '0;
               idx_d    = 3'd0;
            end else begin
               key_valid_d = (state_q == ST_FOUND);
               no_key_d    = (state_q == ST_FAIL);
            end
         end

         ST_LAUNCH: begin
            busy_d     = 1'b1;
            core_rst_d = 1'b0;
            if (!launch_ph_q) begin
               launch_ph_d = 1'b1;
            end else begin
               state_d      = ST_RUN;
               core_start_d = 1'b1;
            end
         end

         ST_RUN: begin
            if (any_found_s) begin
               state_d     = ST_FOUND;
               key_d       = sel_key_s;
               idx_d       = win_idx_s;
               key_valid_d = 1'b1;
            end else if (all_exh_s) begin
               state_d  = ST_FAIL;
               key_d    = '0;
               no_key_d = 1'b1;
            end else begin
               core_rst_d   = 1'b0;
               core_start_d = 1'b1;
               busy_d       = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         launch_ph_q  <= 1'b0;
         core_rst_q   <= 1'b1;
         core_start_q <= 1'b0;
         key_q        <= '0;
         idx_q        <= 3'd0;
         key_valid_q  <= 1'b0;
         no_key_q     <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         launch_ph_q  <= launch_ph_d;
         core_rst_q   <= core_rst_d;
         core_start_q <= core_start_d;
         key_q        <= key_d;
         idx_q        <= idx_d;
         key_valid_q  <= key_valid_d;
         no_key_q     <= no_key_d;
         busy_q       <= busy_d;
      end
   end

   // Elapsed RUN clocks: cleared on launch, saturating at all-ones.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cycles_q <= '0;
      end else if (launch_s) begin
         cycles_q <= '0;
      end else if ((state_q == ST_RUN) && (cycles_q != '1)) begin
         cycles_q <= cycles_q + CNT_W'(1);
      end else begin
         cycles_q <= cycles_q;
      end
   end

   assign core_rst_o   = core_rst_q;
   assign core_start_o = core_start_q;
   assign key_out_o    = key_q;
   assign winner_idx_o = idx_q;
   assign key_valid_o  = key_valid_q;
   assign no_key_o     = no_key_q;
   assign busy_o       = busy_q;
   assign cycles_o     = cycles_q;

endmodule
